// File: rtl/pos_display_pkg.sv
// Shared definitions for the POS display-memory write arbiter.
//   - Default widths and per-blanking write budget.
//   - Arbiter FSM state encoding.
package pos_display_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned MAX_WR_DEF = 64;

  // Width of the per-blanking write counter (MAX_WR is at most 255).
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_BLANK = 2'd0,
    ARB        = 2'd1,
    GRANT      = 2'd2,
    EXHAUSTED  = 2'd3
  } arb_state_e;

endpackage : pos_display_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - index of the requester with highest priority this round
//   win_oh  - one-hot winner (zero when no request)
//   win_idx - binary index of the winner
//   any     - at least one request is set
module rr_picker #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [PTR_W-1:0] win_idx,
  output logic             any
);

  int unsigned idx;

  // Scan from ptr upward with wrap; first set bit wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(ptr) + off) % N_REQ;
      if (!any && req[PTR_W'(idx)]) begin
        any                   = 1'b1;
        win_idx               = PTR_W'(idx);
        win_oh[PTR_W'(idx)]   = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/pos_display_write_arbiter.sv
// Arbitrates display-memory writes from N_REQ requesters into vertical
// blanking, at most one write every two cycles and at most MAX_WR writes
// per blanking interval.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   vblank            - vertical blanking level
//   req/req_addr/data - per-requester write request with address and data
//   gnt               - one-hot grant, coincident with the write
//   wr_en/addr/data   - display-memory write port
//   overrun           - blanking ended with a request still pending
module pos_display_write_arbiter
  import pos_display_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned MAX_WR = MAX_WR_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vblank,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    overrun
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               overrun_q, overrun_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [COUNT_W-1:0] count_q, count_d, count_base;
  logic               vblank_q;

  logic [N_REQ-1:0]   win_oh_c;
  logic [PTR_W-1:0]   win_idx_c;
  logic               any_c;
  logic               vb_rise_c;
  logic               vb_fall_c;

  logic [ADDR_W-1:0]  addr_arr [N_REQ];
  logic [DATA_W-1:0]  data_arr [N_REQ];

  // Unpack the flat request buses into per-requester slots.
  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh_c),
    .win_idx (win_idx_c),
    .any     (any_c)
  );

  assign vb_rise_c = vblank & ~vblank_q;
  assign vb_fall_c = ~vblank & vblank_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ptr_d      = ptr_q;
    // Budget restarts on every blanking rising edge, whatever the state.
    count_base = vb_rise_c ? '0 : count_q;
    count_d    = count_base;
    overrun_d  = vb_fall_c & (|req);

    case (state_q)
      WAIT_BLANK: begin
        if (vblank) state_d = ARB;
      end
      ARB: begin
        if (!vblank) begin
          state_d = WAIT_BLANK;
        end else if (count_base == COUNT_W'(MAX_WR)) begin
          state_d = EXHAUSTED;
        end else if (any_c) begin
          state_d   = GRANT;
          gnt_d     = win_oh_c;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_arr[win_idx_c];
          wr_data_d = data_arr[win_idx_c];
          count_d   = count_base + COUNT_W'(1);
          ptr_d     = (win_idx_c == PTR_W'(N_REQ - 1)) ? '0 : win_idx_c + PTR_W'(1);
        end
      end
      GRANT: begin
        // Write is already on the bus; always return to arbitration.
        state_d = ARB;
      end
      EXHAUSTED: begin
        if (!vblank) state_d = WAIT_BLANK;
      end
      default: state_d = WAIT_BLANK;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_BLANK;
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      overrun_q <= 1'b0;
      ptr_q     <= '0;
      count_q   <= '0;
      vblank_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      overrun_q <= overrun_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      vblank_q  <= vblank;
    end
  end

  assign gnt     = gnt_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign overrun = overrun_q;

endmodule : pos_display_write_arbiter

// File: tb/tb_pos_display_write_arbiter.sv
// Scoreboard bench for pos_display_write_arbiter: dut_a uses default
// parameters, dut_b uses MAX_WR=3 for the write-budget scenario.
module tb_pos_display_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          vblank_a = 1'b0, vblank_b = 1'b0;
  logic [N-1:0]  req_a = '0, req_b = '0;
  logic [N*AW-1:0] req_addr_a = '0, req_addr_b = '0;
  logic [N*DW-1:0] req_data_a = '0, req_data_b = '0;

  logic [N-1:0]  gnt_a, gnt_b;
  logic          wr_en_a, wr_en_b;
  logic [AW-1:0] wr_addr_a, wr_addr_b;
  logic [DW-1:0] wr_data_a, wr_data_b;
  logic          overrun_a, overrun_b;

  pos_display_write_arbiter dut_a (
    .clk(clk), .reset(reset), .vblank(vblank_a), .req(req_a),
    .req_addr(req_addr_a), .req_data(req_data_a), .gnt(gnt_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .overrun(overrun_a)
  );

  pos_display_write_arbiter #(.MAX_WR(3)) dut_b (
    .clk(clk), .reset(reset), .vblank(vblank_b), .req(req_b),
    .req_addr(req_addr_b), .req_data(req_data_b), .gnt(gnt_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .overrun(overrun_b)
  );

  typedef struct {
    logic [N-1:0]  gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   ovr_a[$];
  int   ovr_b[$];

  int   cyc = 0;
  logic rst_smp = 1'b0;
  logic done = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [AW-1:0] last_addr [2];
  logic [DW-1:0] last_data [2];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_smp <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_dut(input string tag, input logic [N-1:0] g, input logic we,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic ov, input int sel);
    exp_t e;
    int   oc;
    bit   have;
    if (rst_smp) begin
      chk({tag, "_rst_gnt"},     32'(g),  32'd0);
      chk({tag, "_rst_wr_en"},   32'(we), 32'd0);
      chk({tag, "_rst_wr_addr"}, 32'(wa), 32'd0);
      chk({tag, "_rst_wr_data"}, 32'(wd), 32'd0);
      chk({tag, "_rst_overrun"}, 32'(ov), 32'd0);
      last_addr[sel] = '0;
      last_data[sel] = '0;
    end else begin
      chk({tag, "_gnt_iff_wr_en"}, 32'(g != '0), 32'(we));
      if (we) begin
        have = (sel == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
        chk({tag, "_write_expected"}, 32'(have), 32'd1);
        if (have) begin
          e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
          chk({tag, "_gnt"},     32'(g),   32'(e.gnt));
          chk({tag, "_wr_addr"}, 32'(wa),  32'(e.addr));
          chk({tag, "_wr_data"}, 32'(wd),  32'(e.data));
          chk({tag, "_wr_cycle"}, 32'(cyc), 32'(e.cyc));
          last_addr[sel] = e.addr;
          last_data[sel] = e.data;
        end
      end else begin
        chk({tag, "_hold_addr"}, 32'(wa), 32'(last_addr[sel]));
        chk({tag, "_hold_data"}, 32'(wd), 32'(last_data[sel]));
      end
      if (ov) begin
        have = (sel == 0) ? (ovr_a.size() != 0) : (ovr_b.size() != 0);
        chk({tag, "_overrun_expected"}, 32'(have), 32'd1);
        if (have) begin
          oc = (sel == 0) ? ovr_a.pop_front() : ovr_b.pop_front();
          chk({tag, "_overrun_cycle"}, 32'(cyc), 32'(oc));
        end
      end
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    mon_dut("a", gnt_a, wr_en_a, wr_addr_a, wr_data_a, overrun_a, 0);
    mon_dut("b", gnt_b, wr_en_b, wr_addr_b, wr_data_b, overrun_b, 1);
    if (cyc > 3000) begin
      chk("watchdog_cycle_bound", 32'(cyc), 32'd3000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end else if (done) begin
      chk("a_pending_writes",   32'(q_a.size()),   32'd0);
      chk("b_pending_writes",   32'(q_b.size()),   32'd0);
      chk("a_pending_overruns", 32'(ovr_a.size()), 32'd0);
      chk("b_pending_overruns", 32'(ovr_b.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int sel, input logic [N-1:0] g, input logic [AW-1:0] ad,
                      input logic [DW-1:0] d, input int c);
    exp_t e;
    e.gnt = g; e.addr = ad; e.data = d; e.cyc = c;
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  initial begin
    int k;
    at(3);
    reset = 1'b0;

    // Single request: write appears one cycle after the ARB sample.
    k = cyc;
    req_addr_a[0 +: AW] = 12'h010;
    req_data_a[0 +: DW] = 8'h55;
    vblank_a = 1'b1;
    req_a    = 4'b0001;
    push(0, 4'b0001, 12'h010, 8'h55, k + 2);
    at(k + 2); req_a = '0;
    at(k + 4); vblank_a = 1'b0;
    at(k + 6); reset = 1'b1;
    at(k + 8); reset = 1'b0;

    // All four held: round-robin rotation, one grant every two cycles.
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      req_addr_a[i*AW +: AW] = AW'(12'h100 + i);
      req_data_a[i*DW +: DW] = DW'(8'hA0 + i);
    end
    vblank_a = 1'b1;
    req_a    = 4'b1111;
    for (int j = 0; j < 8; j++)
      push(0, N'(1 << (j % 4)), AW'(12'h100 + (j % 4)), DW'(8'hA0 + (j % 4)), k + 2 + 2*j);
    at(k + 16); req_a = '0;
    at(k + 18); vblank_a = 1'b0;

    // Blanking ends with a pending request: overrun, then served next blanking.
    at(k + 20);
    k = cyc;
    vblank_a = 1'b1;
    at(k + 3);
    req_addr_a[1*AW +: AW] = 12'h222;
    req_data_a[1*DW +: DW] = 8'h33;
    req_a    = 4'b0010;
    vblank_a = 1'b0;
    ovr_a.push_back(k + 4);
    at(k + 7); vblank_a = 1'b1;
    push(0, 4'b0010, 12'h222, 8'h33, k + 9);
    at(k + 9); req_a = '0; vblank_a = 1'b0;

    // Reset during GRANT, then pointer restarts at requester 0.
    at(k + 13);
    k = cyc;
    req_addr_a[2*AW +: AW] = 12'h3C4;
    req_data_a[2*DW +: DW] = 8'h77;
    vblank_a = 1'b1;
    req_a    = 4'b0100;
    push(0, 4'b0100, 12'h3C4, 8'h77, k + 2);
    at(k + 2); reset = 1'b1; req_a = '0;
    at(k + 3);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr_a[i*AW +: AW] = AW'(12'h400 + i);
      req_data_a[i*DW +: DW] = DW'(8'h10 + i);
    end
    req_a = 4'b1111;
    push(0, 4'b0001, 12'h400, 8'h10, k + 5);
    at(k + 5); req_a = '0; vblank_a = 1'b0;

    // MAX_WR=3: three grants per blanking, budget restored next blanking.
    at(k + 9);
    k = cyc;
    req_addr_b[0 +: AW] = 12'h0AB;
    req_data_b[0 +: DW] = 8'hC3;
    vblank_b = 1'b1;
    req_b    = 4'b0001;
    push(1, 4'b0001, 12'h0AB, 8'hC3, k + 2);
    push(1, 4'b0001, 12'h0AB, 8'hC3, k + 4);
    push(1, 4'b0001, 12'h0AB, 8'hC3, k + 6);
    at(k + 20); vblank_b = 1'b0;
    ovr_b.push_back(k + 21);
    at(k + 23); vblank_b = 1'b1;
    push(1, 4'b0001, 12'h0AB, 8'hC3, k + 25);
    push(1, 4'b0001, 12'h0AB, 8'hC3, k + 27);
    push(1, 4'b0001, 12'h0AB, 8'hC3, k + 29);
    at(k + 29); req_b = '0;
    at(k + 34); vblank_b = 1'b0;
    at(k + 37); done = 1'b1;
  end

endmodule : tb_pos_display_write_arbiter

// File: doc/pos_display_write_arbiter.md
POS_DISPLAY_WRITE_ARBITER -- requirements
Module: pos_display_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter ADDR_W, default 12, display-memory write address width.
REQ-003 Parameter DATA_W, default 8, display-memory write data width.
REQ-004 Parameter MAX_WR, default 64, maximum writes granted per vertical blanking interval (1..255).
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 vblank  in  1  high while the VGA timing generator is in vertical blanking; level, synchronous to clk.
REQ-008 req  in  N_REQ  per-requester write request; bit i held high until gnt[i] is seen.
REQ-009 req_addr  in  N_REQ*ADDR_W  requester i address in slice [i*ADDR_W +: ADDR_W]; stable while req[i] high.
REQ-010 req_data  in  N_REQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W]; stable while req[i] high.
REQ-011 gnt  out  N_REQ  one-hot, one-cycle grant; coincides with the write it represents.
REQ-012 wr_en  out  1  display-memory write strobe.
REQ-013 wr_addr  out  ADDR_W  display-memory write address.
REQ-014 wr_data  out  DATA_W  display-memory write data.
REQ-015 overrun  out  1  one-cycle pulse: blanking ended with at least one request still pending.

Function
REQ-016 FSM states: WAIT_BLANK, ARB, GRANT, EXHAUSTED; all outputs registered.
REQ-017 WAIT_BLANK -> ARB on the cycle vblank is sampled high; otherwise stay.
REQ-018 ARB: if vblank low -> WAIT_BLANK; else if count == MAX_WR -> EXHAUSTED; else if any req -> GRANT; else stay.
REQ-019 On ARB -> GRANT, winner is the first set req bit searching from ptr upward with wrap to 0; the winner's addr/data are latched.
REQ-020 In GRANT: wr_en=1, gnt=one-hot winner, wr_addr/wr_data=latched values, count increments, ptr = (winner+1) mod N_REQ; next state ARB unconditionally.
REQ-021 Throughput: at most one write per two cycles; latency from req sampled in ARB to wr_en/gnt is exactly 1 cycle.
REQ-022 A write in GRANT completes even if vblank falls in that cycle; no grant is issued with vblank low in the preceding ARB cycle.
REQ-023 EXHAUSTED -> WAIT_BLANK when vblank is sampled low; no grants in EXHAUSTED.
REQ-024 count (8 bit) clears to 0 on every vblank rising edge (vblank high, registered vblank_d low); saturates at MAX_WR.
REQ-025 overrun pulses for one cycle on the vblank falling edge when any req bit is high in that cycle.
REQ-026 gnt and wr_en are 0 in every state except GRANT; wr_addr/wr_data hold their last values outside GRANT.
REQ-027 A req bit dropping before grant is legal; that requester is simply not selected.

Reset
REQ-028 On reset: state=WAIT_BLANK, gnt=0, wr_en=0, wr_addr=0, wr_data=0, overrun=0, ptr=0, count=0, vblank_d=0.
REQ-029 Reset asserted in GRANT drops nothing already written but suppresses the next cycle's outputs; no partial or repeated write follows.

Structure
REQ-030 Package pos_display_pkg holds the state encoding and the default values of ADDR_W, DATA_W, MAX_WR.
REQ-031 Sub-module rr_picker (combinational: req, ptr -> one-hot winner, winner index, any) is instantiated once.

Verification
REQ-032 N_REQ=4, vblank high, req=4'b0001 addr 0x010 data 0x55 -> cycle+1 wr_en=1, gnt=0001, wr_addr=0x010, wr_data=0x55.
REQ-033 All four req held high for 8 writes -> gnt order 0001,0010,0100,1000,0001,... one grant every 2 cycles.
REQ-034 MAX_WR=3, req held through a long blanking -> exactly 3 grants, then EXHAUSTED; next blanking grants again from count 0.
REQ-035 vblank falls while req=0010 pending -> no further gnt, overrun=1 for exactly one cycle; grant issued early in next blanking.
REQ-036 reset pulsed during GRANT -> all outputs 0 next cycle, state WAIT_BLANK, ptr=0, count=0.
